// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one outstanding fetch at a time to the
// instruction memory, buffers returned words with their addresses in a small
// prefetch FIFO, and flushes/retargets on datapath redirects.
module instruction_fetch_unit #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [ADDRESS_WIDTH-1:0]      imem_addr,
    input  logic                          imem_ack,
    input  logic [DATA_WIDTH-1:0]         imem_rdata,
    input  logic                          redirect,
    input  logic [ADDRESS_WIDTH-1:0]      redirect_pc,
    input  logic                          instr_ready,
    output logic                          instr_valid,
    output logic [DATA_WIDTH-1:0]         instruction,
    output logic [ADDRESS_WIDTH-1:0]      pc_result,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    word;
    } entry_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;     // address of the outstanding request
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    entry_t                   mem_q [FIFO_DEPTH];
    entry_t                   head;

    logic full, issue, push, pop;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    // Only IDLE may issue, so at most one request is ever in flight and a
    // push can never find the FIFO full.
    assign issue = (state_q == S_IDLE) && !full && !redirect;
    // A word returned while draining, or in the same cycle as a redirect,
    // belongs to the stale path and is dropped.
    assign push  = (state_q == S_WAIT) && imem_ack && !redirect;
    assign pop   = (count_q != '0) && instr_ready && !redirect;

    // Request is raised combinationally in the issuing IDLE cycle and held
    // through WAIT/DRAIN; forced low while reset is asserted.
    assign imem_req  = rst && (issue || (state_q == S_WAIT) || (state_q == S_DRAIN));
    assign imem_addr = (state_q == S_IDLE) ? fetch_pc_q : addr_q;

    assign head        = mem_q[rd_ptr_q];
    assign instr_valid = (count_q != '0);
    assign instruction = instr_valid ? head.word : '0;
    assign pc_result   = instr_valid ? head.addr : '0;
    assign fifo_count  = count_q;

    // Next-state logic for the fetch FSM, fetch PC and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (imem_ack)      state_d = S_IDLE;
                else if (redirect) state_d = S_DRAIN;
                if (push)          fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(1);
            end
            S_DRAIN: begin
                // Stays here across further redirects until the stale ack lands.
                if (imem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            addr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {addr_q, imem_rdata};
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by a random
// phase, all checked each cycle against a transaction-level queue model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [19:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [19:0] instruction;
    logic [7:0]  pc_result;
    logic [2:0]  fifo_count;

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instruction(instruction), .pc_result(pc_result),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [19:0] w;
    } ent_t;

    // Reference model: instruction memory contents, prefetch queue, fetch PC
    // and the single in-flight request (plus whether its word is stale).
    logic [19:0] memv [256];
    ent_t        q [$];
    logic [7:0]  m_pc;
    logic [7:0]  m_oaddr;
    bit          m_out;
    bit          m_drop;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic       obs_req;
    logic [7:0] obs_addr;
    logic       obs_valid;
    logic [7:0] obs_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, check outputs
    // against the model, advance the model, then move to the next falling edge.
    task automatic step(input bit redir, input logic [7:0] rpc, input bit rdy, input int ackmode);
        bit   a;
        bit   ackd;
        int   sz0;
        logic ev;
        a = (ackmode == 1) ? m_out : (ackmode == 2);
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = rdy;
        imem_ack    = a;
        imem_rdata  = m_out ? memv[m_oaddr] : 20'($urandom);
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_pc    = pc_result;

        sz0 = q.size();
        ev  = (sz0 != 0);
        chk("req",   32'(imem_req),    32'(m_out || (sz0 < 4 && !redir)));
        chk("addr",  32'(imem_addr),   32'(m_out ? m_oaddr : m_pc));
        chk("valid", 32'(instr_valid), 32'(ev));
        chk("instr", 32'(instruction), ev ? 32'(q[0].w) : 32'd0);
        chk("pc",    32'(pc_result),   ev ? 32'(q[0].a) : 32'd0);
        chk("count", 32'(fifo_count),  32'(sz0));

        ackd = m_out && a;
        if (redir) begin
            q.delete();
            m_pc = rpc;
            if (ackd) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            if (sz0 > 0 && rdy) void'(q.pop_front());
            if (ackd) begin
                if (!m_drop) begin
                    q.push_back('{a: m_oaddr, w: memv[m_oaddr]});
                    m_pc = m_pc + 8'd1;
                end
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (!m_out && sz0 < 4) begin
                m_out   = 1'b1;
                m_oaddr = m_pc;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Called at a falling edge: assert reset asynchronously, check the reset
    // state, hold for two edges and release at a falling edge.
    task automatic do_reset();
        rst         = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        #1;
        chk("rst_req",   32'(imem_req),    32'd0);
        chk("rst_addr",  32'(imem_addr),   32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_pc",    32'(pc_result),   32'd0);
        chk("rst_count", 32'(fifo_count),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_pc   = 8'd0;
        m_out  = 1'b0;
        m_drop = 1'b0;
    endtask

    initial begin
        bit         r;
        logic [7:0] rp;
        bit         rd;
        int         am;

        for (int i = 0; i < 256; i++) memv[i] = 20'($urandom);
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        m_pc = 8'd0; m_oaddr = 8'd0; m_out = 1'b0; m_drop = 1'b0;
        @(negedge clk);
        do_reset();

        // Streaming fetch until the request to 0x05 is in flight.
        for (int i = 0; i < 50; i++) begin
            if (m_out && m_oaddr == 8'h05) break;
            step(1'b0, 8'h00, 1'b1, 1);
        end
        #1;
        chk("pend5_addr", 32'(imem_addr), 32'h05);

        // Redirect while waiting: drain the stale word, restart at 0x40.
        step(1'b1, 8'h40, 1'b1, 0);
        #1;
        chk("drain_req",   32'(imem_req),    32'd1);
        chk("drain_addr",  32'(imem_addr),   32'h05);
        chk("drain_valid", 32'(instr_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1, 1);
            if (obs_valid) break;
        end
        chk("redir_valid",    32'(obs_valid), 32'd1);
        chk("redir_first_pc", 32'(obs_pc),    32'h40);

        // Wrap-around: fill from 0xFE with the consumer stalled, then drain.
        step(1'b1, 8'hFE, 1'b0, 1);
        repeat (10) step(1'b0, 8'h00, 1'b0, 1);
        step(1'b0, 8'h00, 1'b1, 0);
        chk("wrap0", {31'd0, obs_valid, 24'd0, obs_pc} >> 0 & 32'hFF, 32'hFE);
        step(1'b0, 8'h00, 1'b1, 0);
        chk("wrap1", 32'(obs_pc), 32'hFF);
        step(1'b0, 8'h00, 1'b1, 0);
        chk("wrap2", 32'(obs_pc), 32'h00);

        // Back-pressure: full FIFO stops requests; one pop re-enables issue.
        step(1'b1, 8'h10, 1'b0, 1);
        repeat (12) step(1'b0, 8'h00, 1'b0, 1);
        #1;
        chk("bp_count", 32'(fifo_count), 32'd4);
        chk("bp_req",   32'(imem_req),   32'd0);
        step(1'b0, 8'h00, 1'b1, 0);
        #1;
        chk("bp_reissue_req",  32'(imem_req),  32'd1);
        chk("bp_reissue_addr", 32'(imem_addr), 32'h14);

        // Push and pop in the same cycle at a count of two.
        step(1'b1, 8'h20, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 2 && m_out) break;
            step(1'b0, 8'h00, 1'b0, 1);
        end
        #1;
        chk("pp_pre_count", 32'(fifo_count), 32'd2);
        step(1'b0, 8'h00, 1'b1, 1);
        #1;
        chk("pp_count", 32'(fifo_count), 32'd2);

        // Redirect coincident with the ack: word dropped, no drain needed.
        for (int i = 0; i < 10; i++) begin
            if (m_out) break;
            step(1'b0, 8'h00, 1'b0, 0);
        end
        step(1'b1, 8'h30, 1'b1, 1);
        #1;
        chk("ra_count", 32'(fifo_count),  32'd0);
        chk("ra_valid", 32'(instr_valid), 32'd0);
        chk("ra_addr",  32'(imem_addr),   32'h30);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1);

        // Reset while a request is in flight, then a late ack after release.
        for (int i = 0; i < 10; i++) begin
            if (m_out) break;
            step(1'b0, 8'h00, 1'b0, 0);
        end
        do_reset();
        step(1'b0, 8'h00, 1'b1, 2);
        chk("post_rst_req",  32'(obs_req),  32'd1);
        chk("post_rst_addr", 32'(obs_addr), 32'd0);
        #1;
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        repeat (8) step(1'b0, 8'h00, 1'b1, 1);

        // Random traffic: variable memory latency, stalls, spurious acks, redirects.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(99) < 5);
            rp = 8'($urandom);
            rd = 1'($urandom_range(1));
            if (m_out) am = ($urandom_range(2) != 0) ? 1 : 0;
            else       am = ($urandom_range(9) == 0) ? 2 : 0;
            step(r, rp, rd, am);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
